dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between the pipeline MEM stage (port P) and an auxiliary
//   requester (port A: program loader / debug). Sequences each access over a fixed MEM_LATENCY,
//   stalls the pipeline until its access completes, and prevents A from starving under heavy P load.
//   Sits between the EX/MEM register outputs and data_memory.
// PARAMETERS
//   ADDR_W       32  address width (byte address, passed through unchanged)
//   DATA_W       32  data width
//   MEM_LATENCY  2   cycles m_* are held per access; legal range 1..15
//   STARVE_LIMIT 4   consecutive A losses before A gets priority; legal range 1..255
// PORTS
//   clk      in   1       clock, rising edge
//   rst_n    in   1       asynchronous active-low reset
//   p_read   in   1       MEM-stage load request (level; held while p_stall=1)
//   p_write  in   1       MEM-stage store request (level; held while p_stall=1)
//   p_addr   in   ADDR_W  MEM-stage address
//   p_wdata  in   DATA_W  MEM-stage store data
//   p_rdata  out  DATA_W  load data, valid in the cycle p_stall drops
//   p_stall  out  1       1 = freeze PC/IF/ID/EX/MEM; combinational
//   a_req    in   1       aux request; must be held until a_ack
//   a_we     in   1       aux write enable (sampled with a_req)
//   a_addr   in   ADDR_W  aux address
//   a_wdata  in   DATA_W  aux write data
//   a_rdata  out  DATA_W  aux read data, valid with a_ack
//   a_ack    out  1       one-cycle completion pulse
//   m_addr   out  ADDR_W  memory address
//   m_wdata  out  DATA_W  memory write data
//   m_read   out  1       memory read strobe
//   m_write  out  1       memory write strobe
//   m_rdata  in   DATA_W  memory read data, sampled on the last ACCESS cycle
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, owner=P, cnt=0, starve=0; p_rdata, a_rdata, a_ack, m_addr,
//     m_wdata, m_read, m_write = 0 immediately. Reset during ACCESS aborts it; a partially-timed write
//     is not retried.
//   FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: P request = p_read|p_write. If starve==STARVE_LIMIT and a_req: grant A. Else if P request:
//     grant P. Else if a_req: grant A. On grant: latch addr/wdata/we (P: we=p_write; write wins when
//     p_read&p_write), set owner, cnt=MEM_LATENCY-1, go ACCESS. No request: stay IDLE, m_* = 0.
//   starve: +1 (saturating at STARVE_LIMIT) on each IDLE grant to P while a_req=1; cleared on A grant.
//   ACCESS: m_addr/m_wdata from latch; m_write=we, m_read=!we, for exactly MEM_LATENCY cycles.
//     cnt==0: capture m_rdata into owner's rdata reg (reads only; writes leave rdata unchanged), go RESP.
//   RESP: m_read=m_write=0. owner P: p_stall=0 this cycle. owner A: a_ack=1 this cycle. Next: IDLE.
//   p_stall = (p_read|p_write) & !(state==RESP & owner==P). Under reset p_stall = p_read|p_write.
//   P access latency: MEM_LATENCY+2 cycles from IDLE with P request to p_stall=0.
//   Back-to-back: a new arbitration occurs only in IDLE, so minimum 1 idle cycle between accesses.
//   a_req dropped mid-access: access completes, a_ack still pulses. P request dropped before grant
//     (pipeline flush): nothing issued.
//   No P request and no a_req: p_stall=0, memory idle, counters unchanged.
// CONFIGURATION
//   DMEM_ARB_PERF_EN defined: extra outputs perf_stall [31:0] (+1 each cycle p_stall=1, wraps at
//     2^32) and perf_aux [15:0] (+1 per a_ack, wraps at 2^16); both 0 on reset.
//   DMEM_ARB_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   P load: MEM_LATENCY=2, p_read=1, p_addr=0x10, mem[0x10]=0xDEADBEEF -> p_stall=1 for 3 cycles,
//     m_read=1 for 2 cycles, p_stall=0 with p_rdata=0xDEADBEEF in cycle 4.
//   P store: p_write=1, p_addr=0x20, p_wdata=0x12345678 -> m_write=1, m_addr=0x20 for 2 cycles;
//     later P load of 0x20 returns 0x12345678; p_read&p_write together -> treated as write.
//   Arbitration: a_req and p_read both continuous, STARVE_LIMIT=4 -> grant order P,P,P,P,A,P,P,P,P,A;
//     a_ack pulses exactly once per A grant.
//   A alone: a_req=1, a_we=0, a_addr=0x40 -> a_ack one cycle after 2 ACCESS cycles, a_rdata=mem[0x40];
//     p_stall stays 0 throughout.
//   Reset mid-ACCESS: assert rst_n=0 on 1st ACCESS cycle of a write -> m_write=0, a_ack=0 same cycle;
//     after release: IDLE, starve=0, next P request served normally.
//   DMEM_ARB_PERF_EN: 3 P loads at MEM_LATENCY=2 -> perf_stall=9; 2 A reads -> perf_aux=2.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the three buses around the data-memory arbiter: pipeline MEM port (p_*),
// auxiliary loader/debug port (a_*) and the single-port memory side (m_*).
// slave: the arbiter itself; master: everything around it (pipeline, aux, memory).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // pipeline MEM-stage port
    logic              p_read;
    logic              p_write;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_stall;
    // auxiliary requester port
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_ack;
    // memory port
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  p_read, p_write, p_addr, p_wdata,
        output p_rdata, p_stall,
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_ack,
        output m_addr, m_wdata, m_read, m_write,
        input  m_rdata
    );

    modport master (
        output p_read, p_write, p_addr, p_wdata,
        input  p_rdata, p_stall,
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_ack,
        input  m_addr, m_wdata, m_read, m_write,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between the pipeline MEM stage (P) and an aux requester (A).
// Latency: MEM_LATENCY+2 cycles from IDLE-with-request to completion (p_stall drop / a_ack).
// Backpressure: P is stalled combinationally until its RESP cycle; A holds a_req until a_ack.
// Ports: clk, rst_n (async active-low), bus (dmem_arbiter_if.slave: p_*, a_*, m_*).
// Optional: define DMEM_ARB_PERF_EN to add perf_stall[31:0] / perf_aux[15:0] counters.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_stall,
    output logic [15:0]        perf_aux
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic                owner_p_q;   // 1 = current access belongs to the pipeline
    logic [3:0]          cnt_q;
    logic [7:0]          starve_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   p_rdata_q;
    logic [DATA_W-1:0]   a_rdata_q;

    logic                p_req;
    logic                grant_p, grant_a;
    logic                p_stall, a_ack, m_read, m_write;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;

    assign p_req = bus.p_read | bus.p_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant_p = 1'b0;
        grant_a = 1'b0;
        p_stall = p_req;
        a_ack   = 1'b0;
        m_read  = 1'b0;
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        case (state_q)
            IDLE: begin
                // A's starvation override beats a pending P request
                if (starve_q == STARVE_MAX && bus.a_req) grant_a = 1'b1;
                else if (p_req)                          grant_p = 1'b1;
                else if (bus.a_req)                      grant_a = 1'b1;
                if (grant_p || grant_a) state_d = ACCESS;
            end
            ACCESS: begin
                m_addr  = addr_q;
                m_wdata = wdata_q;
                m_write = we_q;
                m_read  = !we_q;
                if (cnt_q == 4'd0) state_d = RESP;
            end
            RESP: begin
                if (owner_p_q) p_stall = 1'b0;
                else           a_ack   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_p_q <= 1'b1;
            cnt_q     <= '0;
            starve_q  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            p_rdata_q <= '0;
            a_rdata_q <= '0;
        end else begin
            if (grant_p) begin
                owner_p_q <= 1'b1;
                cnt_q     <= CNT_INIT;
                we_q      <= bus.p_write;   // store wins if both strobes are set
                addr_q    <= bus.p_addr;
                wdata_q   <= bus.p_wdata;
                if (bus.a_req && starve_q != STARVE_MAX) starve_q <= starve_q + 8'd1;
            end else if (grant_a) begin
                owner_p_q <= 1'b0;
                cnt_q     <= CNT_INIT;
                we_q      <= bus.a_we;
                addr_q    <= bus.a_addr;
                wdata_q   <= bus.a_wdata;
                starve_q  <= '0;
            end
            if (state_q == ACCESS) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else if (!we_q) begin
                    if (owner_p_q) p_rdata_q <= bus.m_rdata;
                    else           a_rdata_q <= bus.m_rdata;
                end
            end
        end
    end

    assign bus.p_stall = p_stall;
    assign bus.p_rdata = p_rdata_q;
    assign bus.a_ack   = a_ack;
    assign bus.a_rdata = a_rdata_q;
    assign bus.m_addr  = m_addr;
    assign bus.m_wdata = m_wdata;
    assign bus.m_read  = m_read;
    assign bus.m_write = m_write;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
            perf_aux   <= '0;
        end else begin
            if (p_stall) perf_stall <= perf_stall + 32'd1;
            if (a_ack)   perf_aux   <= perf_aux + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4) with a small memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall;
    logic [15:0] perf_aux;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall (perf_stall),
        .perf_aux   (perf_aux)
`endif
    );

    // memory model: combinational read, write on clock edge, preload port for the bench
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_dat = '0;

    always @(posedge clk) begin
        if (pre_we)           mem[pre_addr] <= pre_dat;
        else if (bus.m_write) mem[bus.m_addr[7:0]] <= bus.m_wdata;
    end
    assign bus.m_rdata = mem[bus.m_addr[7:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        tick();
        pre_we = 1'b0;
    endtask

    // P access: drive request, count stall cycles until p_stall drops, return load data
    task automatic do_p(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int stalls, output bit timeout);
        bus.p_read = rd; bus.p_write = wr; bus.p_addr = addr; bus.p_wdata = wdata;
        stalls = 0; timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (!bus.p_stall) begin timeout = 1'b0; break; end
            stalls++;
            @(posedge clk); #1;
        end
        rdata = bus.p_rdata;
        bus.p_read = 1'b0; bus.p_write = 1'b0;
        tick();
    endtask

    // A access: hold a_req until a_ack or the cycle budget expires
    task automatic do_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output bit timeout);
        bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.a_ack) begin timeout = 1'b0; break; end
            @(posedge clk); #1;
        end
        rdata = bus.a_rdata;
        bus.a_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++; if (bus.p_stall !== 1'b0) begin errors++; $display("FAIL rst_p_stall got %b want 0", bus.p_stall); end
        checks++; if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) begin errors++; $display("FAIL rst_m_strobes got %b%b want 00", bus.m_read, bus.m_write); end
        checks++; if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0) begin errors++; $display("FAIL rst_m_bus got %h/%h want 0/0", bus.m_addr, bus.m_wdata); end
        checks++; if (bus.a_ack !== 1'b0) begin errors++; $display("FAIL rst_a_ack got %b want 0", bus.a_ack); end
        checks++; if (bus.p_rdata !== 32'h0 || bus.a_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0/0", bus.p_rdata, bus.a_rdata); end
        bus.p_read = 1'b1; #1;
        checks++; if (bus.p_stall !== 1'b1) begin errors++; $display("FAIL rst_stall_passthru got %b want 1", bus.p_stall); end
        bus.p_read = 1'b0; #1;
`ifdef DMEM_ARB_PERF_EN
        checks++; if (perf_stall !== 32'd0 || perf_aux !== 16'd0) begin errors++; $display("FAIL rst_perf got %0d/%0d want 0/0", perf_stall, perf_aux); end
`endif
    endtask

    task automatic test_p_load();
        bus.p_read = 1'b1; bus.p_addr = 32'h10; #1;
        checks++; if (bus.p_stall !== 1'b1 || bus.m_read !== 1'b0) begin errors++; $display("FAIL load_c1 got stall=%b m_read=%b want 1 0", bus.p_stall, bus.m_read); end
        tick();
        checks++; if (bus.p_stall !== 1'b1 || bus.m_read !== 1'b1 || bus.m_addr !== 32'h10) begin errors++; $display("FAIL load_c2 got stall=%b m_read=%b addr=%h want 1 1 10", bus.p_stall, bus.m_read, bus.m_addr); end
        tick();
        checks++; if (bus.p_stall !== 1'b1 || bus.m_read !== 1'b1) begin errors++; $display("FAIL load_c3 got stall=%b m_read=%b want 1 1", bus.p_stall, bus.m_read); end
        tick();
        checks++; if (bus.p_stall !== 1'b0 || bus.m_read !== 1'b0 || bus.p_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_c4 got stall=%b m_read=%b rdata=%h want 0 0 deadbeef", bus.p_stall, bus.m_read, bus.p_rdata); end
        bus.p_read = 1'b0;
        tick();
    endtask

    task automatic test_p_store();
        logic [31:0] rd;
        int st;
        bit to;
        bus.p_write = 1'b1; bus.p_addr = 32'h20; bus.p_wdata = 32'h12345678;
        tick();
        checks++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0 || bus.m_addr !== 32'h20 || bus.m_wdata !== 32'h12345678) begin errors++; $display("FAIL store_c2 got w=%b r=%b addr=%h data=%h want 1 0 20 12345678", bus.m_write, bus.m_read, bus.m_addr, bus.m_wdata); end
        tick();
        checks++; if (bus.m_write !== 1'b1) begin errors++; $display("FAIL store_c3 got m_write=%b want 1", bus.m_write); end
        tick();
        checks++; if (bus.p_stall !== 1'b0 || bus.m_write !== 1'b0 || bus.p_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_resp got stall=%b w=%b rdata=%h want 0 0 deadbeef", bus.p_stall, bus.m_write, bus.p_rdata); end
        bus.p_write = 1'b0;
        tick();
        do_p(1'b1, 1'b0, 32'h20, 32'h0, rd, st, to);
        checks++; if (to || rd !== 32'h12345678 || st != 3) begin errors++; $display("FAIL store_readback got data=%h stalls=%0d timeout=%0b want 12345678 3 0", rd, st, to); end
        // both strobes set: must behave as a store
        bus.p_read = 1'b1; bus.p_write = 1'b1; bus.p_addr = 32'h30; bus.p_wdata = 32'hCAFEF00D;
        tick();
        checks++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) begin errors++; $display("FAIL rw_is_write got w=%b r=%b want 1 0", bus.m_write, bus.m_read); end
        tick(); tick();
        bus.p_read = 1'b0; bus.p_write = 1'b0;
        tick();
        do_p(1'b1, 1'b0, 32'h30, 32'h0, rd, st, to);
        checks++; if (to || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_readback got %h timeout=%0b want cafef00d", rd, to); end
    endtask

    task automatic test_aux_alone();
        bit stall_seen = 1'b0;
        int ack_cyc = -1;
        logic [31:0] rd = '0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h40;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.p_stall) stall_seen = 1'b1;
            if (bus.a_ack) begin ack_cyc = i; rd = bus.a_rdata; break; end
            @(posedge clk); #1;
        end
        bus.a_req = 1'b0;
        checks++; if (ack_cyc != 3) begin errors++; $display("FAIL aux_ack_cycle got %0d want 3", ack_cyc); end
        checks++; if (rd !== 32'hA5A50040) begin errors++; $display("FAIL aux_rdata got %h want a5a50040", rd); end
        checks++; if (stall_seen) begin errors++; $display("FAIL aux_no_stall got stall=1 want 0"); end
        tick();
        checks++; if (bus.a_ack !== 1'b0) begin errors++; $display("FAIL aux_ack_width got %b want 0", bus.a_ack); end
    endtask

    task automatic test_arbitration();
        logic [9:0] order = '0;
        logic [9:0] want = 10'b10_0001_0000;  // bit i = 1 when the i-th completion is A
        int n = 0;
        int acks = 0;
        bus.p_read = 1'b1; bus.p_addr = 32'h10;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h40;
        for (int i = 0; i < 200 && n < 10; i++) begin
            #1;
            if (!bus.p_stall) begin order[n] = 1'b0; n++; end
            else if (bus.a_ack) begin order[n] = 1'b1; n++; acks++; end
            @(posedge clk); #1;
        end
        bus.p_read = 1'b0; bus.a_req = 1'b0;
        tick();
        checks++; if (n != 10) begin errors++; $display("FAIL arb_completions got %0d want 10", n); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (order[k] !== want[k]) begin errors++; $display("FAIL arb_grant_%0d got %s want %s", k, order[k] ? "A" : "P", want[k] ? "A" : "P"); end
        end
        checks++; if (acks != 2) begin errors++; $display("FAIL arb_ack_count got %0d want 2", acks); end
    endtask

    task automatic test_drop_and_flush();
        bit acked = 1'b0;
        bit issued = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'h50; bus.a_wdata = 32'h0000_0055;
        tick();                       // first ACCESS cycle
        bus.a_req = 1'b0;
        bus.p_read = 1'b1; bus.p_addr = 32'h10; #1;
        checks++; if (bus.p_stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %b want 1", bus.p_stall); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.a_ack) begin acked = 1'b1; break; end
        end
        bus.p_read = 1'b0;            // flushed in the RESP cycle, before any grant
        checks++; if (!acked) begin errors++; $display("FAIL drop_ack got none want pulse"); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.m_read || bus.m_write) issued = 1'b1;
        end
        checks++; if (issued) begin errors++; $display("FAIL flush_issue got access want none"); end
        checks++; if (mem[8'h50] !== 32'h55) begin errors++; $display("FAIL drop_write got %h want 00000055", mem[8'h50]); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        int st;
        bit to;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'h60; bus.a_wdata = 32'h99;
        tick();
        checks++; if (bus.m_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre got m_write=%b want 1", bus.m_write); end
        rst_n = 1'b0; #1;
        checks++; if (bus.m_write !== 1'b0 || bus.a_ack !== 1'b0 || bus.m_addr !== 32'h0) begin errors++; $display("FAIL rstmid_abort got w=%b ack=%b addr=%h want 0 0 0", bus.m_write, bus.a_ack, bus.m_addr); end
        bus.a_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_p(1'b1, 1'b0, 32'h10, 32'h0, rd, st, to);
        checks++; if (to || rd !== 32'hDEADBEEF || st != 3) begin errors++; $display("FAIL rstmid_next got data=%h stalls=%0d timeout=%0b want deadbeef 3 0", rd, st, to); end
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        logic [31:0] s0;
        logic [15:0] a0;
        logic [31:0] rd;
        int st;
        bit to;
        s0 = perf_stall; a0 = perf_aux;
        for (int i = 0; i < 3; i++) do_p(1'b1, 1'b0, 32'h10, 32'h0, rd, st, to);
        checks++; if (perf_stall - s0 !== 32'd9) begin errors++; $display("FAIL perf_stall got %0d want 9", perf_stall - s0); end
        for (int i = 0; i < 2; i++) do_a(1'b0, 32'h40, 32'h0, rd, to);
        checks++; if (perf_aux - a0 !== 16'd2) begin errors++; $display("FAIL perf_aux got %0d want 2", perf_aux - a0); end
    endtask
`endif

    initial begin
        bus.p_read = 1'b0; bus.p_write = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        #2;
        test_reset();
        preload(8'h00, 32'h0);
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h40, 32'hA5A50040);
        preload(8'h50, 32'h0);
        rst_n = 1'b1;
        tick();
        test_p_load();
        test_p_store();
        test_aux_alone();
        test_arbitration();
        test_drop_and_flush();
        test_reset_mid_access();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
